trigger_sequencer: RTL and testbench

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

---
 rtl/larpix_ctrl_pkg.sv | 26 ++
 rtl/trigger_sequencer.sv | 169 ++++++++++++++++
 tb/tb_trigger_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/larpix_ctrl_pkg.sv
// ============================================================================
//  Module      : larpix_ctrl_pkg
//  Description : Shared types and default sizes for the LArPix control blocks.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package larpix_ctrl_pkg;

    // Default counter width (clk cycles) for holdoff / width / period timing
    localparam int DEF_CNT_BITS = 24;
    // Default width of the trigger-count configuration and status
    localparam int DEF_NUM_BITS = 8;

    // Trigger sequencer FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLDOFF = 3'd1,
        PULSE   = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } trig_state_t;

endpackage : larpix_ctrl_pkg

`default_nettype wire

// File: rtl/trigger_sequencer.sv
// ============================================================================
//  Module      : trigger_sequencer
//  Description : Generates a burst of external_trigger pulses with programmable
//                holdoff, pulse width, period and pulse count. One shared
//                down-counter times the HOLDOFF, PULSE and GAP phases.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module trigger_sequencer
    import larpix_ctrl_pkg::*;
#(
    parameter int CNT_BITS = DEF_CNT_BITS,
    parameter int NUM_BITS = DEF_NUM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_BITS-1:0] cfg_holdoff,
    input  logic [CNT_BITS-1:0] cfg_width,
    input  logic [CNT_BITS-1:0] cfg_period,
    input  logic [NUM_BITS-1:0] cfg_num,
    output logic                external_trigger,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] trig_count
);

    localparam logic [CNT_BITS-1:0] c_cnt_one = CNT_BITS'(1);
    localparam logic [NUM_BITS-1:0] c_num_one = NUM_BITS'(1);

    trig_state_t         state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_BITS-1:0] count_q, count_d;
    logic [CNT_BITS-1:0] width_q, width_d;
    logic [CNT_BITS-1:0] period_q, period_d;
    logic [NUM_BITS-1:0] num_q, num_d;
    logic                trig_q, busy_q, done_q;

    logic [CNT_BITS-1:0] w_width_in;
    logic [CNT_BITS-1:0] w_width_lat;
    logic [CNT_BITS-1:0] w_gap_lat;
    logic [NUM_BITS-1:0] w_count_inc;

    // A zero width still produces a one-cycle pulse
    function automatic logic [CNT_BITS-1:0] eff_width(input logic [CNT_BITS-1:0] w);
        return (w == '0) ? c_cnt_one : w;
    endfunction

    // Gap never drops below one cycle, and the subtraction is only taken when
    // the period exceeds the width, so it cannot wrap
    function automatic logic [CNT_BITS-1:0] gap_len(input logic [CNT_BITS-1:0] p,
                                                    input logic [CNT_BITS-1:0] w);
        return (p > w) ? (p - w) : c_cnt_one;
    endfunction

    assign w_width_in  = eff_width(cfg_width);
    assign w_width_lat = eff_width(width_q);
    assign w_gap_lat   = gap_len(period_q, w_width_lat);
    assign w_count_inc = (count_q == '1) ? count_q : (count_q + c_num_one);

    // Next-state, counter and configuration-latch logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        width_d  = width_q;
        period_d = period_q;
        num_d    = num_q;

        if (abort) begin
            // Abort wins over everything except reset; trig_count holds
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        // Holdoff goes straight into the down-counter, so only
                        // width/period/num need a shadow copy
                        width_d  = cfg_width;
                        period_d = cfg_period;
                        num_d    = cfg_num;
                        count_d  = '0;
                        if (cfg_holdoff == '0) begin
                            state_d = PULSE;
                            cnt_d   = w_width_in - c_cnt_one;
                        end else begin
                            state_d = HOLDOFF;
                            cnt_d   = cfg_holdoff - c_cnt_one;
                        end
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == '0) begin
                        state_d = PULSE;
                        cnt_d   = w_width_lat - c_cnt_one;
                    end else begin
                        cnt_d = cnt_q - c_cnt_one;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        count_d = w_count_inc;
                        if ((num_q != '0) && (w_count_inc == num_q)) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            state_d = GAP;
                            cnt_d   = w_gap_lat - c_cnt_one;
                        end
                    end else begin
                        cnt_d = cnt_q - c_cnt_one;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = PULSE;
                        cnt_d   = w_width_lat - c_cnt_one;
                    end else begin
                        cnt_d = cnt_q - c_cnt_one;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counters, latched configuration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            count_q  <= '0;
            width_q  <= '0;
            period_q <= '0;
            num_q    <= '0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            width_q  <= width_d;
            period_q <= period_d;
            num_q    <= num_d;
            // Outputs decoded from the next state so they line up with state_q
            trig_q   <= (state_d == PULSE);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    assign external_trigger = trig_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign trig_count       = count_q;

endmodule : trigger_sequencer

`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
// ============================================================================
//  Module      : tb_trigger_sequencer
//  Description : Directed self-checking bench for trigger_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trigger_sequencer;

    localparam int CNT_BITS = 24;
    localparam int NUM_BITS = 8;

    logic                clk;
    logic                reset;
    logic                start;
    logic                abort;
    logic [CNT_BITS-1:0] cfg_holdoff;
    logic [CNT_BITS-1:0] cfg_width;
    logic [CNT_BITS-1:0] cfg_period;
    logic [NUM_BITS-1:0] cfg_num;
    logic                external_trigger;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] trig_count;

    int n_checks;
    int n_errors;

    // Per-cycle capture, bit k = value in cycle k after the start edge
    logic [63:0] trig_vec;
    logic [63:0] done_vec;
    logic [63:0] busy_vec;

    trigger_sequencer #(
        .CNT_BITS (CNT_BITS),
        .NUM_BITS (NUM_BITS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .cfg_holdoff      (cfg_holdoff),
        .cfg_width        (cfg_width),
        .cfg_period       (cfg_period),
        .cfg_num          (cfg_num),
        .external_trigger (external_trigger),
        .busy             (busy),
        .done             (done),
        .trig_count       (trig_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mask(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int h, input int w, input int p, input int n);
        cfg_holdoff = CNT_BITS'(h);
        cfg_width   = CNT_BITS'(w);
        cfg_period  = CNT_BITS'(p);
        cfg_num     = NUM_BITS'(n);
    endtask

    // Pulse start for one sampling edge; returns in cycle 1
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Record outputs for cycles 1..n; returns in cycle n
    task automatic capture(input int n);
        trig_vec = '0;
        done_vec = '0;
        busy_vec = '0;
        for (int k = 1; k <= n; k++) begin
            trig_vec[k] = external_trigger;
            done_vec[k] = done;
            busy_vec[k] = busy;
            if (k < n) step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({external_trigger, busy, done} !== 3'b000 || trig_count !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: trig=%b busy=%b done=%b count=%0d, want 0 0 0 0",
                     external_trigger, busy, done, trig_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_burst();
        set_cfg(0, 2, 5, 3);
        do_start();
        capture(18);
        n_checks++;
        if (trig_vec !== (mask(1,2) | mask(6,7) | mask(11,12))) begin
            n_errors++;
            $display("FAIL basic_trig: got %h want %h", trig_vec, mask(1,2) | mask(6,7) | mask(11,12));
        end
        n_checks++;
        if (done_vec !== mask(13,13)) begin
            n_errors++;
            $display("FAIL basic_done: got %h want %h", done_vec, mask(13,13));
        end
        n_checks++;
        if (busy_vec !== mask(1,13)) begin
            n_errors++;
            $display("FAIL basic_busy: got %h want %h", busy_vec, mask(1,13));
        end
        n_checks++;
        if (trig_count !== 8'd3) begin
            n_errors++;
            $display("FAIL basic_count: got %0d want 3", trig_count);
        end
    endtask

    task automatic test_holdoff_min_width();
        set_cfg(4, 0, 1, 2);
        do_start();
        capture(12);
        n_checks++;
        if (trig_vec !== (mask(5,5) | mask(7,7))) begin
            n_errors++;
            $display("FAIL holdoff_trig: got %h want %h", trig_vec, mask(5,5) | mask(7,7));
        end
        n_checks++;
        if (done_vec !== mask(8,8)) begin
            n_errors++;
            $display("FAIL holdoff_done: got %h want %h", done_vec, mask(8,8));
        end
        n_checks++;
        if (trig_count !== 8'd2) begin
            n_errors++;
            $display("FAIL holdoff_count: got %0d want 2", trig_count);
        end
    endtask

    task automatic test_continuous_abort();
        set_cfg(0, 3, 10, 0);
        do_start();
        capture(36);
        n_checks++;
        if (trig_vec !== (mask(1,3) | mask(11,13) | mask(21,23) | mask(31,33))) begin
            n_errors++;
            $display("FAIL cont_trig: got %h want %h", trig_vec,
                     mask(1,3) | mask(11,13) | mask(21,23) | mask(31,33));
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || external_trigger !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_busy: busy=%b trig=%b want 0 0", busy, external_trigger);
        end
        n_checks++;
        if (trig_count !== 8'd4) begin
            n_errors++;
            $display("FAIL abort_count: got %0d want 4", trig_count);
        end
        capture(12);
        n_checks++;
        if ((trig_vec | done_vec | busy_vec) !== 64'd0) begin
            n_errors++;
            $display("FAIL abort_quiet: trig=%h done=%h busy=%h want all 0", trig_vec, done_vec, busy_vec);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] t, d, b;
        t = '0; d = '0; b = '0;
        set_cfg(2, 2, 4, 3);
        do_start();
        for (int k = 1; k <= 20; k++) begin
            t[k] = external_trigger;
            d[k] = done;
            b[k] = busy;
            if (k == 3) begin
                set_cfg(0, 7, 9, 1);
                start = 1'b1;
            end else if (k == 13) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        n_checks++;
        if (t !== (mask(3,4) | mask(7,8) | mask(11,12))) begin
            n_errors++;
            $display("FAIL b2b_trig: got %h want %h", t, mask(3,4) | mask(7,8) | mask(11,12));
        end
        n_checks++;
        if (d !== mask(13,13)) begin
            n_errors++;
            $display("FAIL b2b_done: got %h want %h", d, mask(13,13));
        end
        n_checks++;
        if (b !== mask(1,13)) begin
            n_errors++;
            $display("FAIL b2b_busy: got %h want %h", b, mask(1,13));
        end
    endtask

    task automatic test_start_abort_and_reset();
        set_cfg(0, 2, 4, 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        capture(4);
        n_checks++;
        if ((busy_vec | trig_vec) !== 64'd0) begin
            n_errors++;
            $display("FAIL start_abort_idle: busy=%h trig=%h want 0", busy_vec, trig_vec);
        end
        set_cfg(1, 4, 8, 0);
        do_start();
        capture(11);
        n_checks++;
        if (external_trigger !== 1'b1 || trig_count !== 8'd1) begin
            n_errors++;
            $display("FAIL pre_reset: trig=%b count=%0d want 1 1", external_trigger, trig_count);
        end
        reset = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        step();
        n_checks++;
        if ({external_trigger, busy, done} !== 3'b000 || trig_count !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: trig=%b busy=%b done=%b count=%0d want 0 0 0 0",
                     external_trigger, busy, done, trig_count);
        end
        reset = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        step();
    endtask

    task automatic test_wide_pulse();
        set_cfg(0, 6, 4, 2);
        do_start();
        capture(18);
        n_checks++;
        if (trig_vec !== (mask(1,6) | mask(8,13))) begin
            n_errors++;
            $display("FAIL wide_trig: got %h want %h", trig_vec, mask(1,6) | mask(8,13));
        end
        n_checks++;
        if (done_vec !== mask(14,14)) begin
            n_errors++;
            $display("FAIL wide_done: got %h want %h", done_vec, mask(14,14));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0);
        step();
        test_reset();
        test_basic_burst();
        test_holdoff_min_width();
        test_continuous_abort();
        test_back_to_back();
        test_start_abort_and_reset();
        test_wide_pulse();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_trigger_sequencer

`default_nettype wire
